control_sequencer: RTL and testbench



---
 rtl/control_pkg.sv | 38 +++
 rtl/control_sequencer.sv | 108 ++++++++++
 tb/tb_control_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the datapath control sequencer: control-word layout,
// fixed control words and the sequencer state types.
package control_pkg;

  localparam int CW_W = 31;

  // Control-word field positions (MSB..LSB)
  localparam int PSEL_HI   = 30;
  localparam int PSEL_LO   = 29;
  localparam int DA_HI     = 28;
  localparam int DA_LO     = 24;
  localparam int SA_HI     = 23;
  localparam int SA_LO     = 19;
  localparam int SB_HI     = 18;
  localparam int SB_LO     = 14;
  localparam int FSEL_HI   = 13;
  localparam int FSEL_LO   = 9;
  localparam int REGW_BIT  = 8;
  localparam int RAMW_BIT  = 7;
  localparam int ENMEM_BIT = 6;
  localparam int ENALU_BIT = 5;
  localparam int ENB_BIT   = 4;
  localparam int ENPC_BIT  = 3;
  localparam int BSEL_BIT  = 2;
  localparam int PCSEL_BIT = 1;
  localparam int SL_BIT    = 0;

  localparam logic [CW_W-1:0] NOP_CW   = '0;
  localparam logic [CW_W-1:0] FETCH_CW = NOP_CW | (CW_W'(2'b01) << PSEL_LO);

  typedef logic [1:0] exec_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fsm_t;

endpackage

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute sequencer: captures instructions, steps the decoder
// bank through execute states, counts retirements and bounds execute length.
module control_sequencer
  import control_pkg::*;
#(
  parameter int MAX_EXEC = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [31:0]     instr_in,
  input  logic            imem_ready,
  input  logic [CW_W-1:0] dec_controlword,
  input  logic [1:0]      dec_nextState,
  input  logic [63:0]     dec_K,
  output logic [31:0]     ir,
  output logic [1:0]      state,
  output logic [CW_W-1:0] controlword,
  output logic [63:0]     K,
  output logic            fetching,
  output logic            retired,
  output logic [31:0]     instr_count,
  output logic            exec_err
);

  localparam int CNT_W = $clog2(MAX_EXEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_EXEC);

  fsm_t            fsm_q, fsm_d;
  logic [31:0]     ir_q;
  exec_state_t     state_q;
  logic [CNT_W-1:0] exec_cnt_q;
  logic [31:0]     instr_count_q;
  logic            exec_err_q;

  logic capture, done, forced, retire;

  assign capture = (fsm_q == FETCH) && run && imem_ready;
  assign done    = (dec_nextState == 2'b00);
  assign forced  = !done && (exec_cnt_q >= CNT_MAX);
  assign retire  = (fsm_q == EXEC) && (done || forced);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q         <= FETCH;
      ir_q          <= '0;
      state_q       <= 2'b00;
      exec_cnt_q    <= '0;
      instr_count_q <= '0;
      exec_err_q    <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      if (capture) begin
        ir_q       <= instr_in;
        exec_cnt_q <= CNT_W'(1);
      end
      if (fsm_q == EXEC) begin
        if (retire) begin
          state_q       <= 2'b00;
          instr_count_q <= instr_count_q + 32'd1;
          if (forced) exec_err_q <= 1'b1;
        end else begin
          state_q    <= dec_nextState;
          exec_cnt_q <= exec_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Next-state logic
  // NOTE: assign a default before any branch so no path leaves fsm_d
  // unassigned and a latch is inferred.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      FETCH: if (capture) fsm_d = EXEC;
      EXEC:  if (retire)  fsm_d = FETCH;
      default: fsm_d = FETCH;
    endcase
  end

  // Output logic; a reset cycle forces the idle outputs whatever the FSM holds
  always_comb begin
    controlword = NOP_CW;
    K           = '0;
    retired     = 1'b0;
    fetching    = 1'b1;
    if (!reset) begin
      if (fsm_q == EXEC) begin
        controlword = dec_controlword;
        K           = dec_K;
        retired     = retire;
        fetching    = 1'b0;
      end else if (capture) begin
        controlword = FETCH_CW;
      end
    end
  end

  assign ir          = ir_q;
  assign state       = state_q;
  assign instr_count = instr_count_q;
  assign exec_err    = exec_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer with hand-computed expectations.
module tb_control_sequencer;

  localparam logic [30:0] NOP  = 31'h0000_0000;
  localparam logic [30:0] FCW  = 31'h2000_0000;  // Psel=01 at bits 30:29

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] instr_in;
  logic        imem_ready;
  logic [30:0] dec_controlword;
  logic [1:0]  dec_nextState;
  logic [63:0] dec_K;
  logic [31:0] ir;
  logic [1:0]  state;
  logic [30:0] controlword;
  logic [63:0] K;
  logic        fetching;
  logic        retired;
  logic [31:0] instr_count;
  logic        exec_err;

  int tests = 0;
  int fails = 0;

  control_sequencer #(.MAX_EXEC(4)) dut (
    .clock(clock), .reset(reset), .run(run), .instr_in(instr_in),
    .imem_ready(imem_ready), .dec_controlword(dec_controlword),
    .dec_nextState(dec_nextState), .dec_K(dec_K), .ir(ir), .state(state),
    .controlword(controlword), .K(K), .fetching(fetching), .retired(retired),
    .instr_count(instr_count), .exec_err(exec_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, then let inputs be changed and outputs settle before checks
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instr_in = '0; imem_ready = 1'b0;
    dec_controlword = 31'h1234_5678; dec_nextState = 2'b00; dec_K = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    tick();
    check("rst_cw", controlword, NOP);
    check("rst_fetching", fetching, 1);
    check("rst_k", K, 0);
    check("rst_retired", retired, 0);
    reset = 1'b0;
    tick();
    check("post_rst_ir", ir, 0);
    check("post_rst_state", state, 0);
    check("post_rst_count", instr_count, 0);
    check("post_rst_err", exec_err, 0);

    // Minimal two-cycle instruction
    run = 1'b1; imem_ready = 1'b1; instr_in = 32'hD61F_0000; dec_nextState = 2'b00;
    #1;
    check("t1_capture_cw", controlword, FCW);
    check("t1_capture_k", K, 0);
    tick();
    run = 1'b0;
    #1;
    check("t1_ir", ir, 32'hD61F_0000);
    check("t1_exec_cw", controlword, 31'h1234_5678);
    check("t1_exec_k", K, 64'hAAAA_BBBB_CCCC_DDDD);
    check("t1_retired", retired, 1);
    check("t1_fetching", fetching, 0);
    tick();
    check("t1_count", instr_count, 1);
    check("t1_back_fetch", fetching, 1);
    check("t1_no_retire", retired, 0);

    // Memory wait: three stalled fetch cycles, capture on the fourth
    run = 1'b1; imem_ready = 1'b0; instr_in = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_wait_cw", controlword, NOP);
      check("t2_wait_fetching", fetching, 1);
      check("t2_wait_ir", ir, 32'hD61F_0000);
      tick();
    end
    imem_ready = 1'b1;
    #1;
    check("t2_capture_cw", controlword, FCW);
    tick();
    // Three-state instruction: 01, 10, 00
    run = 1'b0; imem_ready = 1'b0; dec_nextState = 2'b01;
    #1;
    check("t3_ir", ir, 32'h1111_1111);
    check("t3_state0", state, 2'b00);
    check("t3_retired0", retired, 0);
    tick();
    dec_nextState = 2'b10;
    #1;
    check("t3_state1", state, 2'b01);
    check("t3_retired1", retired, 0);
    tick();
    dec_nextState = 2'b00;
    #1;
    check("t3_state2", state, 2'b10);
    check("t3_retired2", retired, 1);
    tick();
    check("t3_fetch", fetching, 1);
    check("t3_state_clr", state, 2'b00);
    check("t3_count", instr_count, 2);

    // Runaway instruction: forced retire on the 4th execute cycle
    run = 1'b1; imem_ready = 1'b1; instr_in = 32'h3333_3333; dec_nextState = 2'b01;
    tick();
    run = 1'b0; imem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("t4_state", state, (i == 1) ? 2'b00 : 2'b01);
      check("t4_retired", retired, (i == 4) ? 1 : 0);
      check("t4_err_pending", exec_err, 0);
      tick();
    end
    check("t4_err", exec_err, 1);
    check("t4_fetch", fetching, 1);
    check("t4_count", instr_count, 3);
    tick();
    check("t4_err_sticky", exec_err, 1);

    // Reset during the second execute cycle abandons the instruction
    run = 1'b1; imem_ready = 1'b1; instr_in = 32'h4444_4444; dec_nextState = 2'b01;
    tick();
    run = 1'b0; imem_ready = 1'b0;
    tick();
    reset = 1'b1; dec_nextState = 2'b00;
    #1;
    check("t5_rst_retired", retired, 0);
    check("t5_rst_cw", controlword, NOP);
    check("t5_rst_fetching", fetching, 1);
    tick();
    reset = 1'b0;
    #1;
    check("t5_state", state, 2'b00);
    check("t5_fetch", fetching, 1);
    check("t5_count", instr_count, 0);
    check("t5_err_clr", exec_err, 0);
    check("t5_ir", ir, 0);

    // Counter wrap, with run dropped mid-instruction
    force dut.instr_count_q = 32'hFFFF_FFFF;
    run = 1'b1; imem_ready = 1'b1; instr_in = 32'h5555_5555; dec_nextState = 2'b01;
    tick();
    run = 1'b0;
    #1;
    check("t6_exec1_retired", retired, 0);
    tick();
    dec_nextState = 2'b00;
    #1;
    check("t6_retired", retired, 1);
    release dut.instr_count_q;
    tick();
    check("t6_wrap", instr_count, 0);
    check("t6_fetch", fetching, 1);
    tick();
    check("t6_no_capture_ir", ir, 32'h5555_5555);
    check("t6_no_capture_fetch", fetching, 1);
    check("t6_no_capture_cw", controlword, NOP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
